// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-port round-robin arbiter for the 8-bit SDRAM ext_bus master port
// Optional watchdog: define SDRAM_ARB_TIMEOUT_EN to abort GRANT after TIMEOUT_CYCLES cycles.
module sdram_arbiter #(
    parameter int ADDR_W         = 24,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_50,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_rwb,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_rwb,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic [ADDR_W-1:0] bus_address,
    output logic              bus_read,
    output logic              bus_write,
    output logic [DATA_W-1:0] bus_write_data,
    input  logic              bus_acknowledge,
    input  logic [DATA_W-1:0] bus_read_data,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t            state, state_next;
    logic              last_dma;
    logic              win_dma;
    logic              timed_out;
    logic              done;
    logic [DATA_W-1:0] rd_val;

    // DMA wins when alone, or when both ask and the CPU was served last.
    assign win_dma = dma_req & (~cpu_req | ~last_dma);
    assign done    = (state == GRANT) & (bus_acknowledge | timed_out);
    assign rd_val  = bus_acknowledge ? bus_read_data : '1;

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;

    assign timed_out = (state == GRANT) & ~bus_acknowledge
                     & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            cnt <= (state == GRANT) ? cnt + 1'b1 : '0;
            if (timed_out)
                timeout_err <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timed_out      = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cpu_req | dma_req) state_next = GRANT;
            GRANT:   if (bus_acknowledge | timed_out) state_next = RELEASE;
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            grant          <= 2'b00;
            bus_address    <= '0;
            bus_write_data <= '0;
            bus_read       <= 1'b0;
            bus_write      <= 1'b0;
            cpu_ack        <= 1'b0;
            dma_ack        <= 1'b0;
            cpu_rdata      <= '0;
            dma_rdata      <= '0;
            last_dma       <= 1'b1;
        end else begin
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            if (state == IDLE && (cpu_req | dma_req)) begin
                grant          <= win_dma ? 2'b10 : 2'b01;
                bus_address    <= win_dma ? dma_addr : cpu_addr;
                bus_write_data <= win_dma ? dma_wdata : cpu_wdata;
                bus_read       <= win_dma ? dma_rwb : cpu_rwb;
                bus_write      <= win_dma ? ~dma_rwb : ~cpu_rwb;
            end
            if (done) begin
                bus_read  <= 1'b0;
                bus_write <= 1'b0;
                grant     <= 2'b00;
                last_dma  <= grant[1];
                cpu_ack   <= grant[0];
                dma_ack   <= grant[1];
                if (grant[0] & bus_read)
                    cpu_rdata <= rd_val;
                if (grant[1] & bus_read)
                    dma_rdata <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - scoreboard bench for sdram_arbiter
module tb_sdram_arbiter;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 8;
    localparam int TMO    = 16;

    logic              clk_50 = 1'b0;
    logic              rst = 1'b0;
    logic              cpu_req = 1'b0, cpu_rwb = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              dma_req = 1'b0, dma_rwb = 1'b0;
    logic [ADDR_W-1:0] dma_addr = '0;
    logic [DATA_W-1:0] dma_wdata = '0;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_ack;
    logic [ADDR_W-1:0] bus_address;
    logic              bus_read, bus_write;
    logic [DATA_W-1:0] bus_write_data;
    logic              bus_acknowledge;
    logic [DATA_W-1:0] bus_read_data;
    logic [1:0]        grant;
    logic              timeout_err;

    always #5 clk_50 = ~clk_50;

    sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_50(clk_50), .rst(rst),
        .cpu_req(cpu_req), .cpu_rwb(cpu_rwb), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_rwb(dma_rwb), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .bus_address(bus_address), .bus_read(bus_read), .bus_write(bus_write),
        .bus_write_data(bus_write_data), .bus_acknowledge(bus_acknowledge),
        .bus_read_data(bus_read_data), .grant(grant), .timeout_err(timeout_err)
    );

    typedef struct {
        bit          port;
        bit          rwb;
        logic [23:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        bit          tmo;
    } txn_t;

    txn_t exp_q[$];
    int   checks = 0, failures = 0;
    int   ack_cnt = 0, cyc = 0, last_ack_cyc = -10, last_hi = 0, hi_cnt = 0, latency = 3;
    bit   resp_en = 1'b1, stray_req = 1'b0;
    logic [1:0] prev_acks = 2'b00;

    always @(posedge clk_50) cyc <= cyc + 1;

    // Controller model: acknowledges after the strobe has been high for `latency` cycles.
    initial begin
        bus_acknowledge = 1'b0;
        bus_read_data   = '0;
        forever begin
            @(negedge clk_50);
            if ((bus_read || bus_write) && !bus_acknowledge) begin
                hi_cnt++;
                if (resp_en && hi_cnt >= latency) begin
                    bus_acknowledge = 1'b1;
                    last_hi         = hi_cnt;
                    last_ack_cyc    = cyc;
                    if (exp_q.size() > 0) begin
                        bus_read_data = exp_q[0].rdata;
                        checks++;
                        if (bus_address !== exp_q[0].addr) begin
                            failures++;
                            $display("FAIL bus_address got=%h exp=%h", bus_address, exp_q[0].addr);
                        end
                        checks++;
                        if ({bus_read, bus_write} !== {exp_q[0].rwb, ~exp_q[0].rwb}) begin
                            failures++;
                            $display("FAIL bus_strobes got=%b%b exp_rwb=%b", bus_read, bus_write, exp_q[0].rwb);
                        end
                        if (!exp_q[0].rwb) begin
                            checks++;
                            if (bus_write_data !== exp_q[0].wdata) begin
                                failures++;
                                $display("FAIL bus_write_data got=%h exp=%h", bus_write_data, exp_q[0].wdata);
                            end
                        end
                    end
                end
            end else begin
                bus_acknowledge = stray_req;
                if (stray_req) bus_read_data = 8'h77;
                stray_req = 1'b0;
                hi_cnt    = 0;
            end
        end
    end

    // Requester-side scoreboard: every ack pops the oldest expected transfer.
    initial begin
        txn_t        t;
        logic [7:0]  rd;
        forever begin
            @(negedge clk_50);
            if (cpu_ack || dma_ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL ack_unexpected got=%b%b exp=00", dma_ack, cpu_ack);
                end else begin
                    t = exp_q.pop_front();
                    ack_cnt++;
                    if ({dma_ack, cpu_ack} !== (t.port ? 2'b10 : 2'b01)) begin
                        failures++;
                        $display("FAIL ack_port got=%b%b exp_port=%0d", dma_ack, cpu_ack, t.port);
                    end
                    checks++;
                    if (prev_acks !== 2'b00) begin
                        failures++;
                        $display("FAIL ack_width prev=%b exp=00", prev_acks);
                    end
                    if (!t.tmo) begin
                        checks++;
                        if (cyc !== last_ack_cyc + 1) begin
                            failures++;
                            $display("FAIL ack_latency got=%0d exp=%0d", cyc, last_ack_cyc + 1);
                        end
                    end
                    if (t.rwb) begin
                        checks++;
                        rd = t.port ? dma_rdata : cpu_rdata;
                        if (rd !== t.rdata) begin
                            failures++;
                            $display("FAIL rdata port=%0d got=%h exp=%h", t.port, rd, t.rdata);
                        end
                    end
                end
            end
            prev_acks = {dma_ack, cpu_ack};
        end
    end

    task automatic do_reset();
        @(negedge clk_50);
        rst = 1'b1;
        cpu_req = 1'b0;
        dma_req = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk_50);
        rst = 1'b0;
    endtask

    task automatic wait_ack_drop(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk_50);
            if (cpu_ack || dma_ack) begin
                seen    = 1'b1;
                cpu_req = 1'b0;
                dma_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        @(negedge clk_50);
        checks++;
        if ({grant, bus_read, bus_write, cpu_ack, dma_ack, timeout_err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0", {grant, bus_read, bus_write, cpu_ack, dma_ack, timeout_err});
        end
        checks++;
        if ({cpu_rdata, dma_rdata} !== 16'h0) begin
            failures++;
            $display("FAIL reset_rdata got=%h exp=0000", {cpu_rdata, dma_rdata});
        end
        @(negedge clk_50);
        rst = 1'b0;
        repeat (2) @(negedge clk_50);
        checks++;
        if (grant !== 2'b00) begin
            failures++;
            $display("FAIL reset_idle_grant got=%b exp=00", grant);
        end
    endtask

    task automatic test_cpu_read();
        bit seen;
        latency = 3;
        exp_q.push_back('{port: 1'b0, rwb: 1'b1, addr: 24'h001234, wdata: 8'h00, rdata: 8'hA5, tmo: 1'b0});
        @(negedge clk_50);
        cpu_req = 1'b1; cpu_rwb = 1'b1; cpu_addr = 24'h001234;
        wait_ack_drop(seen);
        checks++;
        if (!seen) begin failures++; $display("FAIL cpu_read_done got=0 exp=1"); end
        checks++;
        if (last_hi !== 3) begin failures++; $display("FAIL cpu_read_strobe_len got=%0d exp=3", last_hi); end
        checks++;
        if (grant !== 2'b00) begin failures++; $display("FAIL cpu_read_release_grant got=%b exp=00", grant); end
        @(negedge clk_50);
        checks++;
        if (cpu_ack !== 1'b0) begin failures++; $display("FAIL cpu_ack_pulse got=%b exp=0", cpu_ack); end
        repeat (3) @(negedge clk_50);
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [3];
        int zrun = 0, ng = 0, acks = 0;
        bit started = 1'b0;
        exp_g = '{2'b01, 2'b10, 2'b01};
        do_reset();
        latency = 2;
        exp_q.push_back('{port: 1'b0, rwb: 1'b0, addr: 24'h000010, wdata: 8'h3C, rdata: 8'h00, tmo: 1'b0});
        exp_q.push_back('{port: 1'b1, rwb: 1'b1, addr: 24'h000020, wdata: 8'h00, rdata: 8'h5A, tmo: 1'b0});
        exp_q.push_back('{port: 1'b0, rwb: 1'b0, addr: 24'h000010, wdata: 8'h3C, rdata: 8'h00, tmo: 1'b0});
        @(negedge clk_50);
        cpu_req = 1'b1; cpu_rwb = 1'b0; cpu_addr = 24'h000010; cpu_wdata = 8'h3C;
        dma_req = 1'b1; dma_rwb = 1'b1; dma_addr = 24'h000020;
        for (int i = 0; i < 100 && acks < 3; i++) begin
            @(negedge clk_50);
            if (grant !== 2'b00) begin
                if (started && zrun > 0) begin
                    checks++;
                    if (zrun !== 2) begin failures++; $display("FAIL rr_gap got=%0d exp=2", zrun); end
                end
                if ((!started || zrun > 0) && ng < 3) begin
                    checks++;
                    if (grant !== exp_g[ng]) begin
                        failures++;
                        $display("FAIL rr_grant idx=%0d got=%b exp=%b", ng, grant, exp_g[ng]);
                    end
                end
                if (!started || zrun > 0) ng++;
                started = 1'b1;
                zrun    = 0;
            end else if (started) begin
                zrun++;
            end
            if (cpu_ack || dma_ack) acks++;
            if (acks == 3) begin cpu_req = 1'b0; dma_req = 1'b0; end
        end
        checks++;
        if (acks !== 3 || ng !== 3) begin
            failures++;
            $display("FAIL rr_count acks=%0d grants=%0d exp=3/3", acks, ng);
        end
        repeat (4) @(negedge clk_50);
    endtask

    task automatic test_input_change();
        bit seen = 1'b0;
        latency = 5;
        exp_q.push_back('{port: 1'b0, rwb: 1'b0, addr: 24'h000300, wdata: 8'hC3, rdata: 8'h00, tmo: 1'b0});
        @(negedge clk_50);
        cpu_req = 1'b1; cpu_rwb = 1'b0; cpu_addr = 24'h000300; cpu_wdata = 8'hC3;
        for (int i = 0; i < 20 && !bus_write; i++) @(negedge clk_50);
        cpu_addr = 24'hFFFFFF; cpu_wdata = 8'h00; cpu_req = 1'b0; cpu_rwb = 1'b1;
        @(negedge clk_50);
        checks++;
        if (bus_address !== 24'h000300) begin
            failures++;
            $display("FAIL hold_addr got=%h exp=000300", bus_address);
        end
        wait_ack_drop(seen);
        checks++;
        if (!seen) begin failures++; $display("FAIL dropped_req_ack got=0 exp=1"); end
        repeat (3) @(negedge clk_50);
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0, saw_dma = 1'b0;
        resp_en = 1'b0;
        latency = 2;
        @(negedge clk_50);
        cpu_req = 1'b1; cpu_rwb = 1'b0; cpu_addr = 24'h000400; cpu_wdata = 8'h11;
        for (int i = 0; i < 20 && !bus_write; i++) @(negedge clk_50);
        @(negedge clk_50);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus_read, bus_write, grant, cpu_ack, dma_ack} !== 6'b0) begin
            failures++;
            $display("FAIL async_reset got=%b exp=000000", {bus_read, bus_write, grant, cpu_ack, dma_ack});
        end
        cpu_req = 1'b0;
        @(negedge clk_50);
        rst     = 1'b0;
        resp_en = 1'b1;
        exp_q.push_back('{port: 1'b1, rwb: 1'b1, addr: 24'h000500, wdata: 8'h00, rdata: 8'hC7, tmo: 1'b0});
        dma_req = 1'b1; dma_rwb = 1'b1; dma_addr = 24'h000500;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_50);
            if (bus_read && grant === 2'b10) saw_dma = 1'b1;
            if (dma_ack) begin seen = 1'b1; dma_req = 1'b0; end
        end
        checks++;
        if (!(seen && saw_dma)) begin
            failures++;
            $display("FAIL dma_after_reset ack=%0d grant_seen=%0d exp=1/1", seen, saw_dma);
        end
        repeat (3) @(negedge clk_50);
    endtask

    task automatic test_stray_ack();
        logic [7:0] c0, d0;
        int n0;
        c0 = cpu_rdata; d0 = dma_rdata; n0 = ack_cnt;
        @(negedge clk_50);
        stray_req = 1'b1;
        repeat (4) @(negedge clk_50);
        checks++;
        if ({cpu_rdata, dma_rdata} !== {c0, d0}) begin
            failures++;
            $display("FAIL stray_rdata got=%h exp=%h", {cpu_rdata, dma_rdata}, {c0, d0});
        end
        checks++;
        if (ack_cnt !== n0 || grant !== 2'b00) begin
            failures++;
            $display("FAIL stray_ack acks=%0d exp=%0d grant=%b", ack_cnt, n0, grant);
        end
    endtask

    task automatic test_timeout();
        bit seen = 1'b0;
        int hi = 0;
        int n0;
        resp_en = 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
        exp_q.push_back('{port: 1'b1, rwb: 1'b1, addr: 24'h000600, wdata: 8'h00, rdata: 8'hFF, tmo: 1'b1});
        @(negedge clk_50);
        dma_req = 1'b1; dma_rwb = 1'b1; dma_addr = 24'h000600;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk_50);
            if (bus_read) hi++;
            if (dma_ack) begin seen = 1'b1; dma_req = 1'b0; end
        end
        checks++;
        if (!seen || hi !== TMO) begin
            failures++;
            $display("FAIL timeout_strobe ack=%0d len=%0d exp=1/%0d", seen, hi, TMO);
        end
        repeat (5) @(negedge clk_50);
        checks++;
        if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%b exp=1", timeout_err); end
        do_reset();
        checks++;
        if (timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_clear got=%b exp=0", timeout_err); end
        resp_en = 1'b1;
`else
        exp_q.push_back('{port: 1'b1, rwb: 1'b1, addr: 24'h000600, wdata: 8'h00, rdata: 8'h5A, tmo: 1'b0});
        n0 = ack_cnt;
        @(negedge clk_50);
        dma_req = 1'b1; dma_rwb = 1'b1; dma_addr = 24'h000600;
        repeat (40) @(negedge clk_50);
        hi = hi_cnt;
        checks++;
        if (bus_read !== 1'b1 || timeout_err !== 1'b0 || ack_cnt !== n0) begin
            failures++;
            $display("FAIL no_timeout read=%b err=%b acks=%0d exp=1/0/%0d", bus_read, timeout_err, ack_cnt, n0);
        end
        resp_en = 1'b1;
        wait_ack_drop(seen);
        checks++;
        if (!seen || hi < TMO) begin
            failures++;
            $display("FAIL late_ack ack=%0d held=%0d exp=1/>=%0d", seen, hi, TMO);
        end
`endif
        repeat (3) @(negedge clk_50);
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_round_robin();
        test_input_change();
        test_reset_mid();
        test_stray_ack();
        test_timeout();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
